io_uart_tx: RTL and testbench

- Memory-mapped 8N1 UART transmitter on the j1 CPU io bus (io_rd/io_wr/io_addr/io_dout/io_din), directly downstream of the CPU's io port.
- CPU writes bytes into a small TX FIFO and reads status.
- A bit-timing FSM drains the FIFO onto a serial line.
- Provides the console path for CPU programs.

---
 rtl/io_uart_tx.sv | 173 +++++++++++++++++
 tb/tb_io_uart_tx.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter for the j1 io bus: a small byte FIFO
// fed by CPU writes, drained by a bit-timing FSM onto uart_tx.
module io_uart_tx #(
    parameter logic [15:0] BASE      = 16'h0000,
    parameter int          FIFO_AW   = 3,
    parameter logic [15:0] DIV_RESET = 16'd433
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_n_i,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [15:0] io_addr,
    input  logic [15:0] io_dout,
    output logic [15:0] io_din,
    output logic        uart_tx
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // Register block and FIFO state
    logic [15:0]        r_div;
    logic               r_ovf;
    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW:0]   r_count;

    // Transmit FSM state
    state_t             r_state;
    logic [15:0]        r_cnt;
    logic [2:0]         r_bit;
    logic [7:0]         r_shift;
    logic               r_tx;

    logic               w_sel;
    logic [1:0]         w_off;
    logic               w_full;
    logic               w_empty;
    logic               w_busy;
    logic               w_pop;
    logic               w_push_req;
    logic               w_push;
    logic               w_wr_div;
    logic               w_wr_stat;

    assign w_sel      = (io_addr[15:2] == BASE[15:2]);
    assign w_off      = io_addr[1:0];
    assign w_full     = (r_count == DEPTH_C);
    assign w_empty    = (r_count == '0);
    assign w_busy     = (r_state != S_IDLE);
    assign w_pop      = (r_state == S_IDLE) && !w_empty;
    assign w_push_req = io_wr && w_sel && (w_off == 2'd0);
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_wr_div   = io_wr && w_sel && (w_off == 2'd1);
    assign w_wr_stat  = io_wr && w_sel && (w_off == 2'd2);

    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_n_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_div   <= DIV_RESET;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_wr_div) begin
                r_div <= io_dout;
            end
            if (w_push_req && !w_push) begin
                r_ovf <= 1'b1;
            end else if (w_wr_stat && io_dout[3]) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= io_dout[7:0];
        end
    end

    // Bit timing: r_cnt is loaded with DIV at every bit start, so a bit spans DIV+1 clocks
    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_n_i) begin
            r_state <= S_IDLE;
            r_tx    <= 1'b1;
            r_cnt   <= '0;
            r_bit   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift <= r_mem[r_rptr];
                        r_cnt   <= r_div;
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_cnt == '0) begin
                        r_cnt   <= r_div;
                        r_bit   <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= S_DATA;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == '0) begin
                        r_cnt <= r_div;
                        if (r_bit == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_tx    <= r_shift[1];
                            r_bit   <= r_bit + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                S_STOP: begin
                    if (r_cnt == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign uart_tx = r_tx;

    always_comb begin
        io_din = 16'h0000;
        if (io_rd && w_sel) begin
            case (w_off)
                2'd1:    io_din = r_div;
                2'd2:    io_din = {12'b0, r_ovf, w_empty, w_full, w_busy};
                default: io_din = 16'h0000;
            endcase
        end
    end

endmodule

// File: tb/tb_io_uart_tx.sv
// Bench for io_uart_tx: drives the io bus and compares uart_tx cycle by cycle
// against a waveform computed from frame arithmetic.
module tb_io_uart_tx;

    localparam logic [15:0] BASE = 16'h0010;

    logic        clk;
    logic        rst_n;
    logic        io_rd;
    logic        io_wr;
    logic [15:0] io_addr;
    logic [15:0] io_dout;
    logic [15:0] io_din;
    logic        uart_tx;

    int checks = 0;
    int passes = 0;

    // Expected frames: byte and divisor per frame, sent back-to-back.
    logic [7:0] fb [0:15];
    int         fd [0:15];
    int         nfr;

    io_uart_tx #(.BASE(BASE), .FIFO_AW(3), .DIV_RESET(16'd433)) dut (
        .sys_clk_i   (clk),
        .sys_rst_n_i (rst_n),
        .io_rd       (io_rd),
        .io_wr       (io_wr),
        .io_addr     (io_addr),
        .io_dout     (io_dout),
        .io_din      (io_din),
        .uart_tx     (uart_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // t = 0 is the first cycle after the pop of frame 0.
    function automatic logic model_tx(input int t);
        int base = 0;
        for (int f = 0; f < nfr; f++) begin
            int bl = fd[f] + 1;
            if (t < base + 10 * bl) begin
                int pos = (t - base) / bl;
                if (pos == 0) return 1'b0;
                if (pos == 9) return 1'b1;
                return fb[f][pos-1];
            end
            base += 10 * bl;
            if (t == base) return 1'b1;
            base += 1;
        end
        return 1'b1;
    endfunction

    function automatic int span();
        int s = 0;
        for (int f = 0; f < nfr; f++) s += 10 * (fd[f] + 1) + 1;
        return s - 1;
    endfunction

    task automatic wr_raw(input logic [15:0] a, input logic [15:0] d);
        io_addr = a;
        io_dout = d;
        io_wr   = 1'b1;
        @(posedge clk);
        #1;
        io_wr   = 1'b0;
    endtask

    task automatic wr(input logic [1:0] off, input logic [15:0] d);
        wr_raw(BASE + {14'b0, off}, d);
    endtask

    task automatic rd_raw(input logic [15:0] a, output logic [15:0] v);
        io_addr = a;
        io_rd   = 1'b1;
        #1;
        v       = io_din;
        io_rd   = 1'b0;
    endtask

    task automatic push_frames();
        for (int f = 0; f < nfr; f++) wr(2'd0, {8'h00, fb[f]});
    endtask

    task automatic test_reset();
        logic [15:0] v;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (uart_tx !== 1'b1) $display("FAIL reset_tx: got %0b expected 1", uart_tx); else passes++;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rd_raw(BASE + 16'd2, v);
        checks++;
        if (v !== 16'h0004) $display("FAIL reset_status: got %h expected 0004", v); else passes++;
        rd_raw(BASE + 16'd1, v);
        checks++;
        if (v !== 16'd433) $display("FAIL reset_div: got %0d expected 433", v); else passes++;
        rd_raw(BASE + 16'd3, v);
        checks++;
        if (v !== 16'h0000) $display("FAIL reset_off3: got %h expected 0000", v); else passes++;
        rd_raw(BASE + 16'd0, v);
        checks++;
        if (v !== 16'h0000) $display("FAIL reset_off0: got %h expected 0000", v); else passes++;
    endtask

    task automatic test_single_frame();
        logic [15:0] v;
        wr(2'd1, 16'd3);
        rd_raw(BASE + 16'd1, v);
        checks++;
        if (v !== 16'd3) $display("FAIL single_div: got %0d expected 3", v); else passes++;
        nfr = 1; fb[0] = 8'h55; fd[0] = 3;
        fork
            begin
                push_frames();
                rd_raw(BASE + 16'd2, v);
                checks++;
                if (v !== 16'h0000) $display("FAIL single_stat_queued: got %h expected 0000", v); else passes++;
                @(posedge clk);
                #1;
                rd_raw(BASE + 16'd2, v);
                checks++;
                if (v !== 16'h0005) $display("FAIL single_stat_busy: got %h expected 0005", v); else passes++;
            end
            begin
                @(posedge clk);
                #1;
                checks++;
                if (uart_tx !== 1'b1) $display("FAIL single_prepop: got %0b expected 1", uart_tx); else passes++;
                for (int t = 0; t < span(); t++) begin
                    @(posedge clk);
                    #1;
                    checks++;
                    if (uart_tx !== model_tx(t))
                        $display("FAIL single_tx t=%0d: got %0b expected %0b", t, uart_tx, model_tx(t));
                    else passes++;
                end
            end
        join
        @(posedge clk);
        #1;
        rd_raw(BASE + 16'd2, v);
        checks++;
        if (v !== 16'h0004) $display("FAIL single_done: got %h expected 0004", v); else passes++;
    endtask

    task automatic test_overflow();
        logic [15:0] v;
        wr(2'd1, 16'd3);
        nfr = 9;
        for (int f = 0; f < 9; f++) begin
            fb[f] = 8'(f + 1);
            fd[f] = 3;
        end
        fork
            begin
                for (int i = 0; i < 10; i++) wr(2'd0, 16'(i + 1));
                rd_raw(BASE + 16'd2, v);
                checks++;
                if (v !== 16'h000B) $display("FAIL ovf_status: got %h expected 000b", v); else passes++;
                wr(2'd2, 16'h0008);
                rd_raw(BASE + 16'd2, v);
                checks++;
                if (v !== 16'h0003) $display("FAIL ovf_clear: got %h expected 0003", v); else passes++;
            end
            begin
                @(posedge clk);
                #1;
                for (int t = 0; t < span(); t++) begin
                    @(posedge clk);
                    #1;
                    checks++;
                    if (uart_tx !== model_tx(t))
                        $display("FAIL ovf_tx t=%0d: got %0b expected %0b", t, uart_tx, model_tx(t));
                    else passes++;
                end
            end
        join
        @(posedge clk);
        #1;
        rd_raw(BASE + 16'd2, v);
        checks++;
        if (v !== 16'h0004) $display("FAIL ovf_done: got %h expected 0004", v); else passes++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] v;
        wr(2'd1, 16'd1);
        nfr = 2; fb[0] = 8'hA5; fd[0] = 1; fb[1] = 8'h3C; fd[1] = 1;
        fork
            push_frames();
            begin
                @(posedge clk);
                #1;
                for (int t = 0; t < span(); t++) begin
                    @(posedge clk);
                    #1;
                    checks++;
                    if (uart_tx !== model_tx(t))
                        $display("FAIL b2b_tx t=%0d: got %0b expected %0b", t, uart_tx, model_tx(t));
                    else passes++;
                end
            end
        join
        @(posedge clk);
        #1;
        rd_raw(BASE + 16'd2, v);
        checks++;
        if (v !== 16'h0004) $display("FAIL b2b_done: got %h expected 0004", v); else passes++;
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] v;
        int lows = 0;
        wr(2'd1, 16'd3);
        nfr = 3; fb[0] = 8'hC3; fb[1] = 8'h5A; fb[2] = 8'hF0;
        fd[0] = 3; fd[1] = 3; fd[2] = 3;
        push_frames();
        for (int t = 2; t <= 17; t++) begin
            @(posedge clk);
            #1;
            checks++;
            if (uart_tx !== model_tx(t))
                $display("FAIL midrst_tx t=%0d: got %0b expected %0b", t, uart_tx, model_tx(t));
            else passes++;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (uart_tx !== 1'b1) $display("FAIL midrst_tx_high: got %0b expected 1", uart_tx); else passes++;
        rst_n = 1'b1;
        rd_raw(BASE + 16'd2, v);
        checks++;
        if (v !== 16'h0004) $display("FAIL midrst_status: got %h expected 0004", v); else passes++;
        rd_raw(BASE + 16'd1, v);
        checks++;
        if (v !== 16'd433) $display("FAIL midrst_div: got %0d expected 433", v); else passes++;
        for (int i = 0; i < 120; i++) begin
            @(posedge clk);
            #1;
            if (uart_tx !== 1'b1) lows++;
        end
        checks++;
        if (lows !== 0) $display("FAIL midrst_no_start: got %0d low cycles expected 0", lows); else passes++;
    endtask

    task automatic test_decode_div_change();
        logic [15:0] v;
        int lows = 0;
        wr(2'd1, 16'd3);
        wr_raw(16'h0014, 16'h0077);
        wr_raw(16'h0015, 16'h0002);
        wr_raw(16'h0016, 16'h0008);
        rd_raw(BASE + 16'd2, v);
        checks++;
        if (v !== 16'h0004) $display("FAIL decode_status: got %h expected 0004", v); else passes++;
        rd_raw(BASE + 16'd1, v);
        checks++;
        if (v !== 16'd3) $display("FAIL decode_div: got %0d expected 3", v); else passes++;
        rd_raw(16'h0015, v);
        checks++;
        if (v !== 16'h0000) $display("FAIL decode_unsel_read: got %h expected 0000", v); else passes++;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (uart_tx !== 1'b1) lows++;
        end
        checks++;
        if (lows !== 0) $display("FAIL decode_no_frame: got %0d low cycles expected 0", lows); else passes++;

        nfr = 2; fb[0] = 8'h96; fd[0] = 3; fb[1] = 8'h3D; fd[1] = 1;
        fork
            begin
                push_frames();
                repeat (36) @(posedge clk);
                #1;
                wr(2'd1, 16'd1);
            end
            begin
                @(posedge clk);
                #1;
                for (int t = 0; t < span(); t++) begin
                    @(posedge clk);
                    #1;
                    checks++;
                    if (uart_tx !== model_tx(t))
                        $display("FAIL divchg_tx t=%0d: got %0b expected %0b", t, uart_tx, model_tx(t));
                    else passes++;
                end
            end
        join
        @(posedge clk);
        #1;
        rd_raw(BASE + 16'd1, v);
        checks++;
        if (v !== 16'd1) $display("FAIL divchg_div: got %0d expected 1", v); else passes++;
    endtask

    task automatic test_random();
        logic [15:0] v;
        for (int it = 0; it < 5; it++) begin
            int d = $urandom_range(1, 3);
            wr(2'd1, 16'(d));
            nfr = $urandom_range(1, 9);
            for (int f = 0; f < nfr; f++) begin
                fb[f] = 8'($urandom);
                fd[f] = d;
            end
            fork
                push_frames();
                begin
                    @(posedge clk);
                    #1;
                    for (int t = 0; t < span(); t++) begin
                        @(posedge clk);
                        #1;
                        checks++;
                        if (uart_tx !== model_tx(t))
                            $display("FAIL rand%0d_tx t=%0d: got %0b expected %0b", it, t, uart_tx, model_tx(t));
                        else passes++;
                    end
                end
            join
            @(posedge clk);
            #1;
            rd_raw(BASE + 16'd2, v);
            checks++;
            if (v !== 16'h0004) $display("FAIL rand%0d_done: got %h expected 0004", it, v); else passes++;
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        io_rd   = 1'b0;
        io_wr   = 1'b0;
        io_addr = 16'h0000;
        io_dout = 16'h0000;
        nfr     = 0;
        test_reset();
        test_single_frame();
        test_overflow();
        test_back_to_back();
        test_reset_mid_frame();
        test_decode_div_change();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
